// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback controller: opcodes, instruction
// field positions, FSM encoding and small opcode-classification helpers.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;

    localparam int OP_MSB = 11;
    localparam int OP_LSB = 9;
    localparam int RD_MSB = 8;
    localparam int RD_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 3;
    localparam int RT_MSB = 2;
    localparam int RT_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

    // Only the arithmetic ops carry a meaningful overflow from the ALU.
    function automatic logic op_has_ovf(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 8-entry register file: two capture-on-enable read ports, one combinational
// debug port and one write port; entry 0 is hardwired to zero.
module regfile8x32
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    output logic [DW-1:0]            qa,
    output logic [DW-1:0]            qb,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [DW-1:0]            wd,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa <= '0;
            qb <= '0;
        end else if (re) begin
            qa <= (ra == '0) ? '0 : mem[ra];
            qb <= (rb == '0) ? '0 : mem[rb];
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue/writeback controller wrapping an external combinational ALU:
// accept, read operands, execute, write back with status flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [11:0]   in_instr,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovf,
    output logic          done,
    output logic [DW-1:0] done_result,
    output logic          done_zero,
    output logic          done_ovf,
    output logic          done_err,
    output logic          ovf_sticky,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [1:0]    state;
    logic [2:0]    op_p0;
    logic [2:0]    rd_p0;
    logic [2:0]    rs_p0;
    logic [2:0]    rt_p0;
    logic [DW-1:0] imm_p0;
    logic [DW-1:0] res_p2;
    logic          ovf_p2;
    logic          err_p2;
    logic          accept;
    logic          rf_we;

    function automatic logic [DW-1:0] sel_result(input logic [2:0]    op,
                                                 input logic [DW-1:0] alu_r,
                                                 input logic [DW-1:0] imm);
        if (op_is_illegal(op)) begin
            return '0;
        end else if (op == OP_LDI) begin
            return imm;
        end
        return alu_r;
    endfunction

    function automatic logic is_zero(input logic [DW-1:0] v);
        return (v == '0);
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign rf_we    = (state == ST_WB) && !err_p2;

    regfile8x32 #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .re       (state == ST_READ),
        .ra       (rs_p0),
        .rb       (rt_p0),
        .qa       (alu_x),
        .qb       (alu_y),
        .we       (rf_we),
        .wa       (rd_p0),
        .wd       (res_p2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_READ;
                ST_READ: state <= ST_EXEC;
                ST_EXEC: state <= ST_WB;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: instruction fields latched at the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p0  <= '0;
            rd_p0  <= '0;
            rs_p0  <= '0;
            rt_p0  <= '0;
            imm_p0 <= '0;
        end else if (accept) begin
            op_p0  <= in_instr[OP_MSB:OP_LSB];
            rd_p0  <= in_instr[RD_MSB:RD_LSB];
            rs_p0  <= in_instr[RS_MSB:RS_LSB];
            rt_p0  <= in_instr[RT_MSB:RT_LSB];
            imm_p0 <= in_imm;
        end
    end

    // Stage p1: opcode presented to the ALU alongside the captured operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= '0;
        end else if (state == ST_READ) begin
            alu_op <= op_p0;
        end
    end

    // Stage p2: ALU outcome sampled at the end of the settled EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p2 <= '0;
            ovf_p2 <= 1'b0;
            err_p2 <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_p2 <= sel_result(op_p0, alu_result, imm_p0);
            ovf_p2 <= op_has_ovf(op_p0) && alu_ovf;
            err_p2 <= op_is_illegal(op_p0);
        end
    end

    // Stage p3: retire; status fields hold until the next retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            done_result <= '0;
            done_zero   <= 1'b0;
            done_ovf    <= 1'b0;
            done_err    <= 1'b0;
            ovf_sticky  <= 1'b0;
        end else begin
            done <= (state == ST_WB);
            if (state == ST_WB) begin
                done_result <= res_p2;
                done_zero   <= is_zero(res_p2);
                done_ovf    <= ovf_p2;
                done_err    <= err_p2;
                ovf_sticky  <= ovf_sticky || ovf_p2;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural stand-in for the ALU;
// the stand-in's overflow flag can be forced to exercise flag routing.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_instr = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] alu_x, alu_y, alu_result;
    logic [2:0]  alu_op;
    logic        alu_ovf;
    logic        done, done_zero, done_ovf, done_err, ovf_sticky;
    logic [31:0] done_result;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        ovf_inj = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mregs [8];
    logic        msticky;

    alu_issue_ctrl dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
        .in_instr (in_instr), .in_imm (in_imm), .alu_x (alu_x), .alu_y (alu_y),
        .alu_op (alu_op), .alu_result (alu_result), .alu_ovf (alu_ovf),
        .done (done), .done_result (done_result), .done_zero (done_zero),
        .done_ovf (done_ovf), .done_err (done_err), .ovf_sticky (ovf_sticky),
        .dbg_addr (dbg_addr), .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: signed overflow for ADD/SUB, plus a forceable overflow.
    always_comb begin
        logic signed [31:0] sx, sy, s;
        sx = alu_x;
        sy = alu_y;
        alu_result = '0;
        alu_ovf    = ovf_inj;
        case (alu_op)
            3'b000: begin
                s = sx + sy; alu_result = s;
                alu_ovf = ovf_inj | ((sx[31] == sy[31]) && (s[31] != sx[31]));
            end
            3'b001: alu_result = alu_x | alu_y;
            3'b010: alu_result = alu_x & alu_y;
            3'b011: begin
                s = sx - sy; alu_result = s;
                alu_ovf = ovf_inj | ((sx[31] != sy[31]) && (s[31] != sx[31]));
            end
            3'b100: alu_result = (sx < sy) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]  op, rd, rs, rt;
        logic [31:0] imm;
        logic        inj;
        logic [31:0] res;
        logic        zero, ovf, err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), dbg_data, mregs[r]);
        end
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_instr = {v.op, v.rd, v.rs, v.rt};
        in_imm   = v.imm;
        ovf_inj  = v.inj;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k < 4) begin
                check($sformatf("ready_busy_k%0d", k), 32'(in_ready), 32'd0);
                check($sformatf("done_early_k%0d", k), 32'(done), 32'd0);
            end
            if (k == 2) begin
                check("exec_alu_x", alu_x, mregs[v.rs]);
                check("exec_alu_y", alu_y, mregs[v.rt]);
                check("exec_alu_op", 32'(alu_op), 32'(v.op));
            end
            if (k == 3) begin
                dbg_addr = v.rd;
                #1;
                check("wb_dbg_old", dbg_data, mregs[v.rd]);
            end
        end
        if (!v.err && v.rd != 0) mregs[v.rd] = v.res;
        msticky = msticky | v.ovf;
        check("done", 32'(done), 32'd1);
        check("done_result", done_result, v.res);
        check("done_zero", 32'(done_zero), 32'(v.zero));
        check("done_ovf", 32'(done_ovf), 32'(v.ovf));
        check("done_err", 32'(done_err), 32'(v.err));
        check("ovf_sticky", 32'(ovf_sticky), 32'(msticky));
        dbg_addr = v.rd;
        #1;
        check("dbg_new", dbg_data, mregs[v.rd]);
        ovf_inj = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'd0);
        check("done_result_hold", done_result, v.res);
    endtask

    initial begin
        int accepts;
        int ready_hi;
        int pulses;

        //             op      rd    rs    rt    imm            inj   res           z     o     e
        vecs[0]  = '{3'b101, 3'd1, 3'd0, 3'd0, 32'h3B9ACA00, 1'b0, 32'h3B9ACA00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b101, 3'd2, 3'd0, 3'd0, 32'hB2D05E00, 1'b0, 32'hB2D05E00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 3'd3, 3'd1, 3'd2, 32'h0,        1'b1, 32'hEE6B2800, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 3'd4, 3'd0, 3'd0, 32'd5,        1'b0, 32'd5,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 3'd5, 3'd0, 3'd0, 32'd5,        1'b0, 32'd5,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 3'd6, 3'd4, 3'd5, 32'h0,        1'b0, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 3'd1, 3'd0, 3'd0, 32'hF0F0F0F0, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 3'd2, 3'd0, 3'd0, 32'h0FF00FF0, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 3'd7, 3'd1, 3'd2, 32'h0,        1'b1, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 3'd3, 3'd1, 3'd2, 32'h0,        1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 3'd0, 3'd0, 3'd0, 32'd7,        1'b0, 32'd7,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b100, 3'd5, 3'd4, 3'd2, 32'h0,        1'b0, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b100, 3'd6, 3'd1, 3'd4, 32'h0,        1'b0, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b000, 3'd4, 3'd4, 3'd4, 32'h0,        1'b0, 32'd10,       1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b110, 3'd1, 3'd2, 3'd3, 32'h1234,     1'b1, 32'd0,        1'b1, 1'b0, 1'b1};
        vecs[15] = '{3'b111, 3'd2, 3'd1, 3'd1, 32'h5678,     1'b0, 32'd0,        1'b1, 1'b0, 1'b1};
        vecs[16] = '{3'b000, 3'd2, 3'd4, 3'd4, 32'h0,        1'b0, 32'd20,       1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 8; r++) mregs[r] = '0;
        msticky = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_result", done_result, 32'd0);
        check("rst_alu_x", alu_x, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check_all_regs("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i]);
            if (vecs[i].err) check_all_regs($sformatf("after_illegal%0d", i));
        end
        check_all_regs("table_end");

        // in_valid held high across two instructions: accepts only in IDLE.
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_instr = {3'b101, 3'd1, 3'd0, 3'd0};
        in_imm   = 32'd11;
        accepts  = 1;
        ready_hi = 0;
        pulses   = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_instr = {3'b101, 3'd2, 3'd0, 3'd0};
                in_imm   = 32'd22;
            end
            if (in_ready) ready_hi++;
            if (in_ready && k < 8) accepts++;
            if (done) pulses++;
            if (k == 4) check("stream_done_k4", 32'(done), 32'd1);
            if (k == 8) check("stream_done_k8", 32'(done), 32'd1);
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(accepts), 32'd2);
        check("stream_ready_cycles", 32'(ready_hi), 32'd2);
        check("stream_pulses", 32'(pulses), 32'd2);
        check("stream_result", done_result, 32'd22);
        mregs[1] = 32'd11;
        mregs[2] = 32'd22;
        check_all_regs("stream");

        // Reset asserted while the ADD sits in EXEC.
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {3'b000, 3'd3, 3'd1, 3'd2};
        in_imm   = '0;
        ovf_inj  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_done_result", done_result, 32'd0);
        check("midrst_alu_x", alu_x, 32'd0);
        check("midrst_alu_y", alu_y, 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_sticky", 32'(ovf_sticky), 32'd0);
        for (int r = 0; r < 8; r++) mregs[r] = '0;
        msticky = 1'b0;
        check_all_regs("midrst");
        @(negedge clk);
        rst_n   = 1'b1;
        ovf_inj = 1'b0;
        pulses  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        check_all_regs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
